// File: rtl/sreg_prog.sv
// Multi-lane delay line with a runtime-programmable depth, built on a circular buffer.
// Tracks fill level, flags valid output and supports a synchronous flush.
module sreg_prog #(
    parameter int D_W       = 32,
    parameter int LANES     = 4,
    parameter int MAX_DEPTH = 16,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_shift_en,
    input  logic                   i_flush,
    input  logic [DEPTH_W-1:0]     i_cfg_depth,
    input  logic [LANES*D_W-1:0]   i_data_in,
    output logic [LANES*D_W-1:0]   o_data_out,
    output logic                   o_out_valid,
    output logic [DEPTH_W-1:0]     o_fill_level
);

    localparam int                 AW    = $clog2(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] C_MAX = DEPTH_W'(MAX_DEPTH);

    logic [LANES*D_W-1:0] r_mem [MAX_DEPTH];
    logic [AW-1:0]        r_wraddr;
    logic [DEPTH_W-1:0]   w_depth;
    logic [AW-1:0]        w_rdaddr;
    logic                 w_shift;

    always_comb begin
        if (i_cfg_depth == '0) begin
            w_depth = DEPTH_W'(1);
        end else if (i_cfg_depth > C_MAX) begin
            w_depth = C_MAX;
        end else begin
            w_depth = i_cfg_depth;
        end
    end

    // A depth of MAX_DEPTH truncates to zero, so the read lands on the entry about to be overwritten.
    assign w_rdaddr = r_wraddr - w_depth[AW-1:0];
    assign w_shift  = i_shift_en && !i_flush && !i_rst;

    always_ff @(posedge i_clk) begin
        if (w_shift) begin
            r_mem[r_wraddr] <= i_data_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wraddr     <= '0;
            o_fill_level <= '0;
            o_data_out   <= '0;
            o_out_valid  <= 1'b0;
        end else if (i_shift_en) begin
            o_data_out  <= r_mem[w_rdaddr];
            o_out_valid <= (o_fill_level >= w_depth);
            r_wraddr    <= r_wraddr + AW'(1);
            if (o_fill_level < C_MAX) begin
                o_fill_level <= o_fill_level + DEPTH_W'(1);
            end
        end
    end

endmodule
